vertex_transform_unit: RTL
==========================

Name: vertex_transform_unit

Overview:
Synthesizable, streaming replacement for the behavioural vertex processor. It applies a loadable 4x4 fixed-point transform matrix to incoming object-space vertices and emits integer screen-space vertices to the rasterizer. It sits directly upstream of the rasterizer.
- Vertex in: Q(M).(N) x/y/z.
- Vertex out: M-bit signed integer x/y/z.
- One shared multiplier, time-multiplexed over 12 multiply-accumulate (MAC) steps per vertex.

Parameters:
M, 11, integer bits of the fixed-point format; also the output coordinate width.
N, 7, fractional bits of the fixed-point format.

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
mat_we  in  1  matrix element write strobe
mat_addr  in  4  element index, row-major (row*4+col)
mat_data  in  M+N  signed Q(M).(N) matrix element
mat_busy  out  1  high while a vertex is in flight; matrix writes are ignored while high
in_valid  in  1  input vertex valid
in_ready  out  1  unit can accept a vertex
in_x, in_y, in_z  in  M+N each  signed Q(M).(N) vertex; w is implicitly 1.0 (1<<N)
out_valid  out  1  transformed vertex valid
out_ready  in  1  downstream accepts
out_x, out_y, out_z  out  M each  signed integer result
out_sat  out  1  one or more components clamped in this vertex

Behaviour:
- Reset is asynchronous on rst_n low, released synchronously by design.
  - State goes to IDLE; out_valid=0; out_sat=0; out_x/y/z=0; mat_busy=0.
  - in_ready goes to 1 once rst_n is high.
  - Matrix resets to identity: diagonal = 1<<N (128), all other elements = 0.
- Matrix write: on a clk edge with mat_we=1 and state==IDLE, element[mat_addr] <= mat_data. The write is ignored in any other state.
- Row 3 is stored but unused; the transform is affine.
- FSM states: IDLE, MAC, OUT.
  - IDLE: in_ready=1. On in_valid&&in_ready, latch in_x/y/z, clear the accumulator and step counter k, and go to MAC.
  - MAC: k counts 0..11, with row r = k/4 and column c = k%4.
    - Each edge does acc += m[r][c]*v[c], where v = {x, y, z, 1<<N}.
    - When c==3, the row result is finalized into the output register for row r and acc is cleared.
    - After k==11, go to OUT.
  - OUT: out_valid=1. Outputs and out_sat are held stable until out_valid&&out_ready. Then go to IDLE.
- Acceptance does not overlap with output: in_ready=0 in MAC and OUT.
- Latency: the accept edge is E0. The MAC terms occur on edges E1..E12. out_valid is high from E12 onward, so it is first visible in the cycle after E12.
- Throughput: at most 1 vertex per 14 cycles when out_ready is held high.
- mat_busy = (state != IDLE).
- Arithmetic:
  - Product width is 2(M+N).
  - Accumulator is 2(M+N)+2 bits, signed, so 4 terms cannot overflow.
  - Row result = acc >>> 2N. This is an arithmetic shift that floors toward -inf.
  - The result is saturated to [-(2^(M-1)), 2^(M-1)-1] = [-1024, 1023].
  - out_sat is the OR of the three per-component clamp events and is latched with the outputs.
- Boundary conditions:
  - in_valid may drop without handshake while in IDLE; no state change results.
  - mat_we in the same cycle as the input handshake: the write takes effect, and the accepted vertex uses the updated matrix. Writes are applied before the first MAC edge.
  - rst_n low mid-MAC or in OUT: the vertex is discarded, out_valid=0 immediately, and the matrix returns to identity.
  - out_ready high while out_valid=0 has no effect.

Test Plan:
- Reset identity: after reset, send (10,20,30)<<7 = (1280,2560,3840) -> out (10,20,30), out_sat=0. out_valid rises after the 12th edge following accept.
- Loaded matrix: write rows {83,-48,-83,0},{34,118,-34,0},{90,0,90,0},{0,0,0,128}, then send (1280,0,0) -> out (6,2,7). With (128,128,128) -> out_x = floor(-6144/16384) = -1.
- Translation: identity plus m[0][3]=640, vertex (0,0,0) -> out (5,0,0).
- Saturation:
  - Diagonal 512, vertex x=1023<<7 -> out_x=1023, out_sat=1.
  - Vertex x=-1023<<7 -> out_x=-1024, out_sat=1.
  - A following in-range vertex -> out_sat=0.
- Backpressure: out_ready low for 20 cycles -> out_x/y/z/sat stable, in_ready=0, mat_busy=1. A mat_we issued during this window is ignored; verify by sending the next vertex and checking identity results.
- Reset mid-operation: pull rst_n low 5 cycles after accept -> out_valid=0 at once. After release, in_ready=1, and vertex (1280,0,0) -> out (10,0,0), confirming the identity matrix is restored.

Source files
------------

// File: rtl/vertex_transform_unit_if.sv
// Bus bundle for vertex_transform_unit: matrix write port plus the input/output
// vertex streams. The unit uses the slave view; the producer/consumer side uses master.
interface vertex_transform_unit_if #(
  parameter int M = 11,
  parameter int N = 7
);
  localparam int W = M + N;

  logic                mat_we;
  logic [3:0]          mat_addr;
  logic signed [W-1:0] mat_data;
  logic                mat_busy;

  logic                in_valid;
  logic                in_ready;
  logic signed [W-1:0] in_x;
  logic signed [W-1:0] in_y;
  logic signed [W-1:0] in_z;

  logic                out_valid;
  logic                out_ready;
  logic signed [M-1:0] out_x;
  logic signed [M-1:0] out_y;
  logic signed [M-1:0] out_z;
  logic                out_sat;

  modport master (
    output mat_we, mat_addr, mat_data,
    output in_valid, in_x, in_y, in_z,
    output out_ready,
    input  mat_busy, in_ready,
    input  out_valid, out_x, out_y, out_z, out_sat
  );

  modport slave (
    input  mat_we, mat_addr, mat_data,
    input  in_valid, in_x, in_y, in_z,
    input  out_ready,
    output mat_busy, in_ready,
    output out_valid, out_x, out_y, out_z, out_sat
  );
endinterface

// File: rtl/vertex_transform_unit.sv
// Affine vertex transform: one shared multiplier walks the 3x4 upper part of a
// loadable Q(M).(N) matrix in 12 MAC steps, emitting saturated integer x/y/z.
module vertex_transform_unit #(
  parameter int M = 11,
  parameter int N = 7
) (
  input  logic                  clk,
  input  logic                  rst_n,
  vertex_transform_unit_if.slave bus
);
  localparam int W  = M + N;
  localparam int PW = 2 * W;
  localparam int AW = PW + 2;

  localparam logic signed [W-1:0]  ONE     = W'(1 << N);
  localparam logic signed [AW-1:0] SAT_MAX = AW'((1 << (M - 1)) - 1);
  localparam logic signed [AW-1:0] SAT_MIN = ~SAT_MAX;

  typedef enum logic [1:0] {IDLE, MAC, OUT} state_t;

  state_t              state_q, state_d;
  logic [3:0]          k_q, k_d;
  logic signed [AW-1:0] acc_q, acc_d;
  logic signed [W-1:0] vx_q, vx_d, vy_q, vy_d, vz_q, vz_d;
  logic signed [M-1:0] ox_q, ox_d, oy_q, oy_d, oz_q, oz_d;
  logic                sat_q, sat_d;
  logic signed [W-1:0] mat_q [16];
  logic signed [W-1:0] mat_d [16];

  logic signed [W-1:0]  m_sel;
  logic signed [W-1:0]  v_sel;
  logic signed [PW-1:0] prod;
  logic signed [AW-1:0] row_sum;
  logic signed [AW-1:0] row_res;
  logic signed [M-1:0]  clamped;
  logic                 clamp_hit;

  // Writes land only in IDLE, so a write on the accept edge is seen by the first MAC.
  always_comb begin
    for (int i = 0; i < 16; i++) begin
      mat_d[i] = mat_q[i];
      if (bus.mat_we && (state_q == IDLE) && (bus.mat_addr == 4'(i))) begin
        mat_d[i] = bus.mat_data;
      end
    end
  end

  always_comb begin
    m_sel = mat_q[k_q];
    case (k_q[1:0])
      2'd0:    v_sel = vx_q;
      2'd1:    v_sel = vy_q;
      2'd2:    v_sel = vz_q;
      default: v_sel = ONE;
    endcase
    prod    = PW'(m_sel) * PW'(v_sel);
    row_sum = acc_q + AW'(prod);
    row_res = row_sum >>> (2 * N);
    clamp_hit = 1'b0;
    if (row_res > SAT_MAX) begin
      clamped   = SAT_MAX[M-1:0];
      clamp_hit = 1'b1;
    end else if (row_res < SAT_MIN) begin
      clamped   = SAT_MIN[M-1:0];
      clamp_hit = 1'b1;
    end else begin
      clamped = row_res[M-1:0];
    end
  end

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    acc_d   = acc_q;
    vx_d    = vx_q;
    vy_d    = vy_q;
    vz_d    = vz_q;
    ox_d    = ox_q;
    oy_d    = oy_q;
    oz_d    = oz_q;
    sat_d   = sat_q;
    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          vx_d    = bus.in_x;
          vy_d    = bus.in_y;
          vz_d    = bus.in_z;
          acc_d   = '0;
          k_d     = '0;
          state_d = MAC;
        end
      end
      MAC: begin
        k_d = k_q + 4'd1;
        if (k_q[1:0] == 2'd3) begin
          // Column 3 closes a row: finalize it and restart the accumulator.
          acc_d = '0;
          case (k_q[3:2])
            2'd0: begin ox_d = clamped; sat_d = clamp_hit;         end
            2'd1: begin oy_d = clamped; sat_d = sat_q | clamp_hit; end
            2'd2: begin oz_d = clamped; sat_d = sat_q | clamp_hit; end
            default: ;
          endcase
          if (k_q == 4'd11) begin
            state_d = OUT;
          end
        end else begin
          acc_d = row_sum;
        end
      end
      OUT: begin
        if (bus.out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      k_q     <= '0;
      acc_q   <= '0;
      vx_q    <= '0;
      vy_q    <= '0;
      vz_q    <= '0;
      ox_q    <= '0;
      oy_q    <= '0;
      oz_q    <= '0;
      sat_q   <= 1'b0;
      for (int i = 0; i < 16; i++) begin
        mat_q[i] <= (i % 5 == 0) ? ONE : '0;
      end
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      acc_q   <= acc_d;
      vx_q    <= vx_d;
      vy_q    <= vy_d;
      vz_q    <= vz_d;
      ox_q    <= ox_d;
      oy_q    <= oy_d;
      oz_q    <= oz_d;
      sat_q   <= sat_d;
      for (int i = 0; i < 16; i++) begin
        mat_q[i] <= mat_d[i];
      end
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.mat_busy  = (state_q != IDLE);
  assign bus.out_valid = (state_q == OUT);
  assign bus.out_x     = ox_q;
  assign bus.out_y     = oy_q;
  assign bus.out_z     = oz_q;
  assign bus.out_sat   = sat_q;
endmodule
